// File: rtl/gpu_pkg.sv
// Shared GPU definitions: frame scheduler states and default PPU array size.
package gpu_pkg;

   localparam int GPU_CORES_COUNT = 10;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_RENDER,
      FS_WAIT_VSYNC,
      FS_SWAP
   } frame_state_t;

endpackage

// File: rtl/frame_swap_ctrl.sv
// Double-buffer frame scheduler: starts PPU render passes, collects done pulses,
// and flips the scanout buffer only on a scanout end-of-frame.
module frame_swap_ctrl
   import gpu_pkg::*;
#(
   parameter int CORES_COUNT = GPU_CORES_COUNT,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   frame_req_valid,
   output logic                   frame_req_ready,
   output logic                   core_start,
   input  logic [CORES_COUNT-1:0] core_done,
   input  logic                   scan_frame_end,
   output logic                   front_sel,
   output logic                   swap_pulse,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic [FRAME_CNT_W-1:0] late_count,
   output logic                   protocol_err
);

   frame_state_t r_state, w_next;

   logic [CORES_COUNT-1:0] r_done_mask;
   logic [CORES_COUNT-1:0] w_mask_or;
   logic [FRAME_CNT_W-1:0] r_frame_count;
   logic [FRAME_CNT_W-1:0] r_late_count;
   logic                   r_core_start;
   logic                   r_front_sel;
   logic                   r_protocol_err;
   logic                   w_all_done;
   logic                   w_accept;
   logic                   w_dup;
   logic                   w_stray;
   logic                   w_late;

   always_comb begin
      w_next     = r_state;
      w_mask_or  = r_done_mask | core_done;
      w_all_done = &w_mask_or;
      w_accept   = 1'b0;
      w_dup      = 1'b0;
      w_stray    = 1'b0;
      w_late     = 1'b0;
      unique case (r_state)
         FS_IDLE: begin
            w_stray  = |core_done;
            w_accept = frame_req_valid;
            if (frame_req_valid)
               w_next = FS_RENDER;
         end
         FS_RENDER: begin
            w_dup = |(core_done & r_done_mask);
            if (w_all_done)
               w_next = scan_frame_end ? FS_SWAP : FS_WAIT_VSYNC;
            else
               w_late = scan_frame_end;
         end
         FS_WAIT_VSYNC: begin
            w_stray = |core_done;
            if (scan_frame_end)
               w_next = FS_SWAP;
         end
         FS_SWAP: begin
            w_stray = |core_done;
            w_next  = FS_IDLE;
         end
         default: w_next = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state        <= FS_IDLE;
         r_done_mask    <= '0;
         r_core_start   <= 1'b0;
         r_front_sel    <= 1'b0;
         r_frame_count  <= '0;
         r_late_count   <= '0;
         r_protocol_err <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_core_start <= w_accept;
         if (w_accept)
            r_done_mask <= '0;
         else if (r_state == FS_RENDER)
            r_done_mask <= w_mask_or;
         if (r_state == FS_SWAP) begin
            r_front_sel   <= ~r_front_sel;
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
         end
         // Repeated-frame counter saturates so a stalled renderer stays visible.
         if (w_late && (r_late_count != '1))
            r_late_count <= r_late_count + FRAME_CNT_W'(1);
         if (w_dup || w_stray)
            r_protocol_err <= 1'b1;
      end
   end

   assign frame_req_ready = (r_state == FS_IDLE);
   assign busy            = (r_state != FS_IDLE);
   assign swap_pulse      = (r_state == FS_SWAP);
   assign core_start      = r_core_start;
   assign front_sel       = r_front_sel;
   assign frame_count     = r_frame_count;
   assign late_count      = r_late_count;
   assign protocol_err    = r_protocol_err;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Directed bench for frame_swap_ctrl: a 4-core/16-bit instance and a
// 1-core/2-bit instance for counter wrap and saturation.
module tb_frame_swap_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        frame_req_valid = 1'b0;
   logic        frame_req_ready;
   logic        core_start;
   logic [3:0]  core_done = '0;
   logic        scan_frame_end = 1'b0;
   logic        front_sel;
   logic        swap_pulse;
   logic        busy;
   logic [15:0] frame_count;
   logic [15:0] late_count;
   logic        protocol_err;

   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        s_start;
   logic [0:0]  s_done = '0;
   logic        s_scan = 1'b0;
   logic        s_front;
   logic        s_swap;
   logic        s_busy;
   logic [1:0]  s_count;
   logic [1:0]  s_late;
   logic        s_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   frame_swap_ctrl #(.CORES_COUNT(4), .FRAME_CNT_W(16)) u_dut (
      .clk(clk), .resetn(resetn),
      .frame_req_valid(frame_req_valid), .frame_req_ready(frame_req_ready),
      .core_start(core_start), .core_done(core_done),
      .scan_frame_end(scan_frame_end), .front_sel(front_sel),
      .swap_pulse(swap_pulse), .busy(busy),
      .frame_count(frame_count), .late_count(late_count),
      .protocol_err(protocol_err)
   );

   frame_swap_ctrl #(.CORES_COUNT(1), .FRAME_CNT_W(2)) u_small (
      .clk(clk), .resetn(resetn),
      .frame_req_valid(s_valid), .frame_req_ready(s_ready),
      .core_start(s_start), .core_done(s_done),
      .scan_frame_end(s_scan), .front_sel(s_front),
      .swap_pulse(s_swap), .busy(s_busy),
      .frame_count(s_count), .late_count(s_late),
      .protocol_err(s_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req();
      frame_req_valid = 1'b1;
      tick();
      frame_req_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      checks++;
      if ({frame_req_ready, core_start, front_sel, swap_pulse, busy, protocol_err}
          !== 6'b100000) begin
         errors++;
         $display("FAIL %s flags: got %b want 100000", tag,
                  {frame_req_ready, core_start, front_sel, swap_pulse, busy, protocol_err});
      end
      checks++;
      if ({frame_count, late_count} !== 32'h0) begin
         errors++;
         $display("FAIL %s counters: got %h/%h want 0/0", tag, frame_count, late_count);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #2;
      check_reset_vals("reset");
      checks++;
      if ({s_ready, s_busy, s_count, s_late} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_small: got %b want 100000", {s_ready, s_busy, s_count, s_late});
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_single_core_pass();
      do_req();
      checks++;
      if ({core_start, busy, frame_req_ready} !== 3'b110) begin
         errors++;
         $display("FAIL t1_start: got %b want 110", {core_start, busy, frame_req_ready});
      end
      for (int i = 0; i < 4; i++) begin
         core_done = 4'(1 << i);
         tick();
         if (i == 0) begin
            checks++;
            if (core_start !== 1'b0) begin
               errors++;
               $display("FAIL t1_start_pulse: got %b want 0", core_start);
            end
         end
      end
      core_done = '0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({swap_pulse, busy, front_sel} !== 3'b010) begin
            errors++;
            $display("FAIL t1_wait%0d: got %b want 010", i, {swap_pulse, busy, front_sel});
         end
         tick();
      end
      scan_frame_end = 1'b1;
      tick();
      scan_frame_end = 1'b0;
      checks++;
      if ({swap_pulse, front_sel} !== 2'b10) begin
         errors++;
         $display("FAIL t1_swap: got %b want 10", {swap_pulse, front_sel});
      end
      tick();
      checks++;
      if ({swap_pulse, front_sel, busy, frame_count, late_count} !== {3'b010, 16'd1, 16'd0}) begin
         errors++;
         $display("FAIL t1_done: got %b cnt %0d late %0d want 010 1 0",
                  {swap_pulse, front_sel, busy}, frame_count, late_count);
      end
   endtask

   task automatic test_done_vsync_same_cycle();
      scan_frame_end = 1'b1;
      tick();
      scan_frame_end = 1'b0;
      checks++;
      if ({late_count, busy} !== {16'd0, 1'b0}) begin
         errors++;
         $display("FAIL t2_idle_vsync: got late %0d busy %b want 0 0", late_count, busy);
      end
      do_req();
      core_done = 4'hf;
      scan_frame_end = 1'b1;
      tick();
      core_done = '0;
      scan_frame_end = 1'b0;
      checks++;
      if (swap_pulse !== 1'b1) begin
         errors++;
         $display("FAIL t2_swap: got %b want 1", swap_pulse);
      end
      tick();
      checks++;
      if ({front_sel, frame_count, late_count} !== {1'b0, 16'd2, 16'd0}) begin
         errors++;
         $display("FAIL t2_done: got front %b cnt %0d late %0d want 0 2 0",
                  front_sel, frame_count, late_count);
      end
   endtask

   task automatic test_late_vsync();
      do_req();
      repeat (3) begin
         scan_frame_end = 1'b1;
         tick();
         scan_frame_end = 1'b0;
         tick();
      end
      checks++;
      if ({late_count, front_sel, busy, swap_pulse} !== {16'd3, 3'b010}) begin
         errors++;
         $display("FAIL t3_late: got late %0d flags %b want 3 010",
                  late_count, {front_sel, busy, swap_pulse});
      end
      core_done = 4'hf;
      tick();
      core_done = '0;
      checks++;
      if ({busy, swap_pulse, front_sel} !== 3'b100) begin
         errors++;
         $display("FAIL t3_wait: got %b want 100", {busy, swap_pulse, front_sel});
      end
      scan_frame_end = 1'b1;
      tick();
      scan_frame_end = 1'b0;
      tick();
      checks++;
      if ({front_sel, frame_count, late_count} !== {1'b1, 16'd3, 16'd3}) begin
         errors++;
         $display("FAIL t3_done: got front %b cnt %0d late %0d want 1 3 3",
                  front_sel, frame_count, late_count);
      end
   endtask

   task automatic test_protocol_err();
      do_req();
      core_done = 4'b0100;
      tick();
      checks++;
      if (protocol_err !== 1'b0) begin
         errors++;
         $display("FAIL t4_first_done: got %b want 0", protocol_err);
      end
      tick();
      core_done = '0;
      checks++;
      if ({protocol_err, busy, swap_pulse} !== 3'b110) begin
         errors++;
         $display("FAIL t4_dup: got %b want 110", {protocol_err, busy, swap_pulse});
      end
      core_done = 4'b1011;
      tick();
      core_done = '0;
      scan_frame_end = 1'b1;
      tick();
      scan_frame_end = 1'b0;
      checks++;
      if (swap_pulse !== 1'b1) begin
         errors++;
         $display("FAIL t4_swap: got %b want 1", swap_pulse);
      end
      tick();
      checks++;
      if ({frame_count, front_sel, protocol_err} !== {16'd4, 2'b01}) begin
         errors++;
         $display("FAIL t4_done: got cnt %0d front %b err %b want 4 0 1",
                  frame_count, front_sel, protocol_err);
      end
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check_reset_vals("t4_reset");
      @(negedge clk);
      resetn = 1'b1;
      core_done = 4'b0001;
      tick();
      core_done = '0;
      checks++;
      if ({protocol_err, busy} !== 2'b10) begin
         errors++;
         $display("FAIL t4_idle_done: got %b want 10", {protocol_err, busy});
      end
      tick();
      checks++;
      if (protocol_err !== 1'b1) begin
         errors++;
         $display("FAIL t4_sticky: got %b want 1", protocol_err);
      end
   endtask

   task automatic test_back_to_back();
      do_req();
      core_done = 4'hf;
      scan_frame_end = 1'b1;
      tick();
      core_done = '0;
      scan_frame_end = 1'b0;
      frame_req_valid = 1'b1;
      checks++;
      if ({swap_pulse, frame_req_ready} !== 2'b10) begin
         errors++;
         $display("FAIL t5_swap_ready: got %b want 10", {swap_pulse, frame_req_ready});
      end
      tick();
      checks++;
      if ({swap_pulse, frame_req_ready, core_start, busy, front_sel, frame_count}
          !== {5'b01001, 16'd1}) begin
         errors++;
         $display("FAIL t5_idle: got %b cnt %0d want 01001 1",
                  {swap_pulse, frame_req_ready, core_start, busy, front_sel}, frame_count);
      end
      tick();
      frame_req_valid = 1'b0;
      checks++;
      if ({core_start, busy, frame_req_ready} !== 3'b110) begin
         errors++;
         $display("FAIL t5_accept: got %b want 110", {core_start, busy, frame_req_ready});
      end
      core_done = 4'hf;
      scan_frame_end = 1'b1;
      tick();
      core_done = '0;
      scan_frame_end = 1'b0;
      tick();
      checks++;
      if ({frame_count, front_sel} !== {16'd2, 1'b0}) begin
         errors++;
         $display("FAIL t5_done: got cnt %0d front %b want 2 0", frame_count, front_sel);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         tick();
         s_valid = 1'b0;
         s_done = 1'b1;
         s_scan = 1'b1;
         tick();
         s_done = 1'b0;
         s_scan = 1'b0;
         tick();
         if (i == 3) begin
            checks++;
            if ({s_count, s_front} !== 3'b000) begin
               errors++;
               $display("FAIL t5_wrap4: got cnt %0d front %b want 0 0", s_count, s_front);
            end
         end
      end
      checks++;
      if ({s_count, s_front, s_late, s_err} !== 6'b011000) begin
         errors++;
         $display("FAIL t5_wrap5: got cnt %0d front %b late %0d err %b want 1 1 0 0",
                  s_count, s_front, s_late, s_err);
      end
   endtask

   task automatic test_async_reset();
      do_req();
      core_done = 4'b0011;
      tick();
      core_done = '0;
      checks++;
      if ({busy, frame_count, protocol_err} !== {1'b1, 16'd2, 1'b1}) begin
         errors++;
         $display("FAIL t6_pre: got busy %b cnt %0d err %b want 1 2 1",
                  busy, frame_count, protocol_err);
      end
      #3;
      resetn = 1'b0;
      #1;
      check_reset_vals("t6_async");
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_saturate();
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      repeat (3) begin
         s_scan = 1'b1;
         tick();
      end
      checks++;
      if (s_late !== 2'd3) begin
         errors++;
         $display("FAIL t6_late3: got %0d want 3", s_late);
      end
      repeat (2) tick();
      s_scan = 1'b0;
      checks++;
      if ({s_late, s_busy, s_swap} !== 4'b1110) begin
         errors++;
         $display("FAIL t6_sat: got late %0d busy %b swap %b want 3 1 0", s_late, s_busy, s_swap);
      end
      s_done = 1'b1;
      tick();
      s_done = 1'b0;
      s_scan = 1'b1;
      tick();
      s_scan = 1'b0;
      tick();
      checks++;
      if ({s_count, s_front, s_late} !== 5'b01111) begin
         errors++;
         $display("FAIL t6_small_done: got cnt %0d front %b late %0d want 1 1 3",
                  s_count, s_front, s_late);
      end
   endtask

   initial begin
      test_reset();
      test_single_core_pass();
      test_done_vsync_same_cycle();
      test_late_vsync();
      test_protocol_err();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
